// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ctrl_pkg : shared encodings for the multi-cycle MIPS controller            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXE    = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JMP  = 2'b10;
  localparam logic [1:0] NPC_JR   = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;

  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_RA   = 2'b10;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_MEM   = 2'b01;
  localparam logic [1:0] WD_PC4   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_instr_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_decode : maps the IR contents to instruction class flags             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_rtype,
  output logic        is_subu,
  output logic        is_ori,
  output logic        is_lui,
  output logic        is_lw,
  output logic        is_sw,
  output logic        is_beq,
  output logic        is_j,
  output logic        is_jal,
  output logic        is_jr,
  output logic        is_nop
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_bits;

  assign op          = instr[31:26];
  assign funct       = instr[5:0];
  assign unused_bits = ^instr[25:6];

  assign is_subu  = (op == OP_RTYPE) && (funct == FN_SUBU);
  assign is_rtype = (op == OP_RTYPE) && ((funct == FN_ADDU) || (funct == FN_SUBU));
  assign is_jr    = (op == OP_RTYPE) && (funct == FN_JR);
  assign is_ori   = (op == OP_ORI);
  assign is_lui   = (op == OP_LUI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);
  // Anything unrecognised, including unsupported R-type functs, retires as a NOP.
  assign is_nop   = ~(is_rtype | is_jr | is_ori | is_lui | is_lw | is_sw |
                      is_beq | is_j | is_jal);

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_ctrl : multi-cycle MIPS main controller with retired-instruction count  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mc_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic [1:0]       npc_op,
  output logic [1:0]       ext_op,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             reg_wr,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             mem_req,
  output logic             mem_wr,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t state;
  state_t next_state;

  logic is_rtype, is_subu, is_ori, is_lui, is_lw, is_sw;
  logic is_beq, is_j, is_jal, is_jr, is_nop;
  logic jump_class;
  logic retire;
  logic [1:0] ext_sel;
  logic [1:0] alu_sel;
  logic       src_sel;

  instr_decode u_decode (
    .instr    (instr),
    .is_rtype (is_rtype),
    .is_subu  (is_subu),
    .is_ori   (is_ori),
    .is_lui   (is_lui),
    .is_lw    (is_lw),
    .is_sw    (is_sw),
    .is_beq   (is_beq),
    .is_j     (is_j),
    .is_jal   (is_jal),
    .is_jr    (is_jr),
    .is_nop   (is_nop)
  );

  assign jump_class = is_j | is_jal | is_jr | is_nop;
  assign ext_sel    = is_lui ? EXT_LUI :
                      (is_lw | is_sw | is_beq) ? EXT_SIGN : EXT_ZERO;
  assign alu_sel    = (is_subu | is_beq) ? ALU_SUB : (is_ori ? ALU_OR : ALU_ADD);
  assign src_sel    = is_ori | is_lui | is_lw | is_sw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: next_state = jump_class ? S_FETCH : S_EXE;
      S_EXE: begin
        if (is_beq)              next_state = S_FETCH;
        else if (is_lw || is_sw) next_state = S_MEM;
        else                     next_state = S_WB;
      end
      S_MEM: begin
        if (mem_ack) next_state = is_lw ? S_WB : S_FETCH;
      end
      S_WB:     next_state = S_FETCH;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    ir_wr   = 1'b0;
    retire  = 1'b0;
    npc_op  = NPC_PC4;
    ext_op  = EXT_ZERO;
    alu_op  = ALU_ADD;
    alu_src = 1'b0;
    reg_wr  = 1'b0;
    reg_dst = DST_RT;
    wd_sel  = WD_ALU;
    mem_req = 1'b0;
    mem_wr  = 1'b0;
    if (state == S_DECODE || state == S_EXE || state == S_MEM || state == S_WB) begin
      ext_op = ext_sel;
    end
    // ALU controls stay live through MEM so the memory address is stable.
    if (state == S_EXE || state == S_MEM) begin
      alu_op  = alu_sel;
      alu_src = src_sel;
    end
    case (state)
      S_FETCH: ir_wr = 1'b1;
      S_DECODE: begin
        if (jump_class) begin
          retire = 1'b1;
          if (is_j || is_jal) npc_op = NPC_JMP;
          else if (is_jr)     npc_op = NPC_JR;
          if (is_jal) begin
            reg_wr  = 1'b1;
            reg_dst = DST_RA;
            wd_sel  = WD_PC4;
          end
        end
      end
      S_EXE: begin
        if (is_beq) begin
          retire = 1'b1;
          npc_op = zero ? NPC_BR : NPC_PC4;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_wr  = is_sw;
        retire  = is_sw & mem_ack;
      end
      S_WB: begin
        retire  = 1'b1;
        reg_wr  = 1'b1;
        reg_dst = is_rtype ? DST_RD : DST_RT;
        wd_sel  = is_lw ? WD_MEM : WD_ALU;
      end
      default: ;
    endcase
  end

  assign pc_wr      = retire;
  assign instr_done = retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_cnt <= '0;
    end else if (retire) begin
      instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mc_ctrl : directed self-checking bench with per-instruction model       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mc_ctrl;

  localparam int CW = 2;

  typedef struct packed {
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] npc_op;
    logic [1:0] ext_op;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       mem_req;
    logic       mem_wr;
    logic       instr_done;
  } outs_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   instr;
  logic          zero;
  logic          mem_ack;
  logic          ir_wr, pc_wr, alu_src, reg_wr, mem_req, mem_wr, instr_done;
  logic [1:0]    npc_op, ext_op, alu_op, reg_dst, wd_sel;
  logic [CW-1:0] instr_cnt;

  outs_t         act;
  outs_t         exp_vec;
  logic [CW-1:0] exp_cnt;
  bit            chk_en;
  int            checks = 0;
  int            errors = 0;
  outs_t         eq[$];
  logic          aq[$];

  always #5 clk = ~clk;

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .zero       (zero),
    .mem_ack    (mem_ack),
    .ir_wr      (ir_wr),
    .pc_wr      (pc_wr),
    .npc_op     (npc_op),
    .ext_op     (ext_op),
    .alu_op     (alu_op),
    .alu_src    (alu_src),
    .reg_wr     (reg_wr),
    .reg_dst    (reg_dst),
    .wd_sel     (wd_sel),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .instr_done (instr_done),
    .instr_cnt  (instr_cnt)
  );

  assign act = {ir_wr, pc_wr, npc_op, ext_op, alu_op, alu_src, reg_wr,
                reg_dst, wd_sel, mem_req, mem_wr, instr_done};

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (act !== exp_vec) begin
        errors++;
        $display("FAIL outputs t=%0t actual=%h expected=%h", $time, act, exp_vec);
      end
      checks++;
      if (instr_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL instr_cnt t=%0t actual=%0d expected=%0d", $time, instr_cnt, exp_cnt);
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Expected per-cycle outputs from FETCH to retirement, written from the
  // instruction's architectural behaviour; noise drives mem_ack high outside MEM.
  task automatic build(input logic [31:0] iv, input logic z, input int w, input bit noise);
    logic [5:0] op, fn;
    bit rt, subu, jr, ori, lui, lw, sw, beq, j, jal, nop;
    logic [1:0] ext;
    outs_t v, e;
    op   = iv[31:26];
    fn   = iv[5:0];
    rt   = (op == 6'h00) && (fn == 6'h21 || fn == 6'h23);
    subu = (op == 6'h00) && (fn == 6'h23);
    jr   = (op == 6'h00) && (fn == 6'h08);
    ori  = (op == 6'h0d);
    lui  = (op == 6'h0f);
    lw   = (op == 6'h23);
    sw   = (op == 6'h2b);
    beq  = (op == 6'h04);
    j    = (op == 6'h02);
    jal  = (op == 6'h03);
    nop  = !(rt || jr || ori || lui || lw || sw || beq || j || jal);
    ext  = lui ? 2'd2 : ((lw || sw || beq) ? 2'd1 : 2'd0);
    eq.delete();
    aq.delete();
    v = '0; v.ir_wr = 1'b1;
    eq.push_back(v); aq.push_back(noise);
    v = '0; v.ext_op = ext;
    if (j || jal || jr || nop) begin
      v.pc_wr = 1'b1; v.instr_done = 1'b1;
      v.npc_op = jr ? 2'd3 : (nop ? 2'd0 : 2'd2);
      if (jal) begin v.reg_wr = 1'b1; v.reg_dst = 2'd2; v.wd_sel = 2'd2; end
      eq.push_back(v); aq.push_back(noise);
      return;
    end
    eq.push_back(v); aq.push_back(noise);
    e = '0; e.ext_op = ext;
    e.alu_op  = (subu || beq) ? 2'd1 : (ori ? 2'd2 : 2'd0);
    e.alu_src = ori || lui || lw || sw;
    if (beq) begin
      e.pc_wr = 1'b1; e.instr_done = 1'b1; e.npc_op = z ? 2'd1 : 2'd0;
      eq.push_back(e); aq.push_back(noise);
      return;
    end
    eq.push_back(e); aq.push_back(noise);
    if (lw || sw) begin
      for (int k = 0; k <= w; k++) begin
        v = e; v.mem_req = 1'b1; v.mem_wr = sw;
        if (sw && k == w) begin v.pc_wr = 1'b1; v.instr_done = 1'b1; end
        eq.push_back(v); aq.push_back(k == w);
      end
      if (sw) return;
    end
    v = '0; v.ext_op = ext; v.reg_wr = 1'b1;
    v.reg_dst = rt ? 2'd1 : 2'd0;
    v.wd_sel  = lw ? 2'd1 : 2'd0;
    v.pc_wr = 1'b1; v.instr_done = 1'b1;
    eq.push_back(v); aq.push_back(noise);
  endtask

  task automatic step(input outs_t v, input logic ack, output logic d, output logic m);
    exp_vec = v;
    mem_ack = ack;
    #3;
    d = instr_done;
    m = mem_req;
    @(posedge clk);
    if (v.instr_done) exp_cnt = exp_cnt + 1'b1;
    #1;
  endtask

  task automatic run(input string name, input logic [31:0] iv, input logic z, input int w,
                     input bit noise, input int lat, input int mreq_cycles);
    int done_at;
    int mr;
    logic d, m;
    done_at = -1;
    mr = 0;
    build(iv, z, w, noise);
    instr = iv;
    zero  = z;
    foreach (eq[i]) begin
      step(eq[i], aq[i], d, m);
      if (d === 1'b1 && done_at < 0) done_at = i + 1;
      if (m === 1'b1) mr++;
    end
    mem_ack = 1'b0;
    check({name, " retire cycle"}, done_at, lat);
    check({name, " mem_req cycles"}, mr, mreq_cycles);
  endtask

  task automatic idle_after_reset();
    logic d, m;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_cnt = '0;
    step('0, 1'b0, d, m);
  endtask

  initial begin
    logic d, m;
    reset = 1'b1; instr = 32'h0; zero = 1'b0; mem_ack = 1'b0;
    exp_vec = '0; exp_cnt = '0; chk_en = 1'b1;
    @(posedge clk);
    idle_after_reset();

    run("lui",     32'h3C01_1234, 1'b0, 0, 1'b0, 4, 0);
    check("cnt after lui", int'(instr_cnt), 1);
    run("beq z1",  32'h1000_0004, 1'b1, 0, 1'b0, 3, 0);
    run("beq z0",  32'h1000_0004, 1'b0, 0, 1'b0, 3, 0);
    run("lw w3",   32'h8C01_0004, 1'b0, 3, 1'b0, 8, 4);
    run("sw w0",   32'hAC01_0008, 1'b0, 0, 1'b1, 4, 1);
    run("jal",     32'h0C00_0010, 1'b0, 0, 1'b0, 2, 0);
    run("illegal", 32'hFC00_0000, 1'b0, 0, 1'b0, 2, 0);
    run("ori",     32'h3421_0001, 1'b0, 0, 1'b1, 4, 0);
    run("subu",    32'h0022_1823, 1'b0, 0, 1'b0, 4, 0);
    run("addu",    32'h0022_1821, 1'b1, 0, 1'b0, 4, 0);
    run("jr",      32'h03E0_0008, 1'b0, 0, 1'b0, 2, 0);
    run("j",       32'h0800_0010, 1'b0, 0, 1'b0, 2, 0);
    check("cnt after 12 retires", int'(instr_cnt), 0);

    // Abort a lw while it waits in MEM.
    build(32'h8C01_0004, 1'b0, 20, 1'b0);
    instr = 32'h8C01_0004;
    for (int i = 0; i < 5; i++) step(eq[i], aq[i], d, m);
    check("mem_req before abort", int'(mem_req), 1);
    #2 reset = 1'b1;
    exp_vec = '0;
    #1;
    check("mem_req async drop", int'(mem_req), 0);
    check("cnt no retire on abort", int'(instr_cnt), 0);
    @(posedge clk);
    idle_after_reset();

    run("w j",     32'h0800_0010, 1'b0, 0, 1'b0, 2, 0);
    run("w sll",   32'h0000_0000, 1'b0, 0, 1'b0, 2, 0);
    run("w jr",    32'h03E0_0008, 1'b0, 0, 1'b0, 2, 0);
    check("cnt before wrap", int'(instr_cnt), 3);
    run("w addu",  32'h0022_1821, 1'b0, 0, 1'b0, 4, 0);
    check("cnt wrap", int'(instr_cnt), 0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
